// File: rtl/vga_pkg.sv
// Shared timing constants, RGB332 palette and output payload for the VGA controller.
// Optional feature macro: VGA_BORDER_EN (red 1-pixel frame around the active area).
package vga_pkg;

   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BACK   = 48;
   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FRONT  = 16;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BACK   = 33;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FRONT  = 10;
   localparam int unsigned BAR_W    = 80;

   localparam int unsigned H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
   localparam int unsigned V_ACT_START = V_SYNC + V_BACK;
   localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
   localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

   localparam int unsigned CNT_W     = 10;
   localparam int unsigned RGB_W     = 8;
   localparam int unsigned BAR_N     = 8;
   localparam int unsigned BAR_IDX_W = 3;

   localparam logic [RGB_W-1:0] RGB_WHITE   = 8'hFF;
   localparam logic [RGB_W-1:0] RGB_YELLOW  = 8'hFC;
   localparam logic [RGB_W-1:0] RGB_CYAN    = 8'h1F;
   localparam logic [RGB_W-1:0] RGB_GREEN   = 8'h1C;
   localparam logic [RGB_W-1:0] RGB_MAGENTA = 8'hE3;
   localparam logic [RGB_W-1:0] RGB_RED     = 8'hE0;
   localparam logic [RGB_W-1:0] RGB_BLUE    = 8'h03;
   localparam logic [RGB_W-1:0] RGB_BLACK   = 8'h00;

   // Bar colours left to right across the visible line.
   localparam logic [RGB_W-1:0] BAR_COLOUR [BAR_N] = '{
      RGB_WHITE, RGB_YELLOW, RGB_CYAN, RGB_GREEN,
      RGB_MAGENTA, RGB_RED, RGB_BLUE, RGB_BLACK
   };

   typedef struct packed {
      logic             hs;
      logic             vs;
      logic [RGB_W-1:0] rgb;
   } vga_pins_t;

   // Syncs are active low, so the idle (reset) state drives them high.
   localparam vga_pins_t PINS_RESET = '{hs: 1'b1, vs: 1'b1, rgb: RGB_BLACK};

   function automatic logic [BAR_IDX_W-1:0] bar_index(input logic [CNT_W-1:0] x);
      return BAR_IDX_W'(x / CNT_W'(BAR_W));
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider and horizontal/vertical raster counters for 640x480@60.
// Counters step once per two system clocks and restart cleanly on reset.
module vga_timing
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             h_active,
   output logic             v_active
);

   logic pix_en;
   logic h_last;
   logic v_last;

   assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
   assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

   // Divide-by-two enable: counters move on edges where pix_en is already 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_en <= 1'b0;
      end else begin
         pix_en <= ~pix_en;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + CNT_W'(1);
            end
         end else begin
            h_cnt <= h_cnt + CNT_W'(1);
         end
      end
   end

   assign h_active = (h_cnt >= CNT_W'(H_ACT_START)) && (h_cnt < CNT_W'(H_ACT_END));
   assign v_active = (v_cnt >= CNT_W'(V_ACT_START)) && (v_cnt < CNT_W'(V_ACT_END));

endmodule

// File: rtl/vga_control.sv
// Fixed-mode 640x480@60 VGA controller producing syncs and an RGB332 colour-bar pattern.
// Define VGA_BORDER_EN to overlay a 1-pixel red frame on the active area.
module vga_control
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic [7:0] vga_rgb
);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_active;
   logic             v_active;
   logic [CNT_W-1:0] x;
   logic [RGB_W-1:0] pattern;
   vga_pins_t        pins_next;
   vga_pins_t        pins_q;

   vga_timing u_timing (
      .clk      (clk),
      .rst      (rst),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .h_active (h_active),
      .v_active (v_active)
   );

   // Active-area column; meaningless outside the visible window, where it is gated off.
   assign x = h_cnt - CNT_W'(H_ACT_START);

`ifdef VGA_BORDER_EN
   logic [CNT_W-1:0] y;
   logic             border;

   assign y      = v_cnt - CNT_W'(V_ACT_START);
   assign border = (x == '0) || (x == CNT_W'(H_ACTIVE - 1)) ||
                   (y == '0) || (y == CNT_W'(V_ACTIVE - 1));
`endif

   // Pattern decode: bars in the visible window, black during blanking.
   always_comb begin
      pattern = RGB_BLACK;
      if (h_active && v_active) begin
         pattern = BAR_COLOUR[bar_index(x)];
`ifdef VGA_BORDER_EN
         if (border) begin
            pattern = RGB_RED;
         end
`endif
      end
   end

   always_comb begin
      pins_next     = PINS_RESET;
      pins_next.hs  = (h_cnt >= CNT_W'(H_SYNC));
      pins_next.vs  = (v_cnt >= CNT_W'(V_SYNC));
      pins_next.rgb = pattern;
   end

   // Every output is registered, one clk behind the counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pins_q <= PINS_RESET;
      end else begin
         pins_q <= pins_next;
      end
   end

   assign vga_hs  = pins_q.hs;
   assign vga_vs  = pins_q.vs;
   assign vga_rgb = pins_q.rgb;

endmodule

// File: tb/tb_vga_control.sv
// Scoreboard bench for vga_control: closed-form raster model per clk plus sync-timing monitors.
module tb_vga_control;

   localparam int HT = 800;
   localparam int VT = 525;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [7:0] rgb;
   } exp_t;

   localparam exp_t RESET_EXP = '{hs: 1'b1, vs: 1'b1, rgb: 8'h00};

   logic       clk;
   logic       rst;
   logic       vga_hs;
   logic       vga_vs;
   logic [7:0] vga_rgb;

   exp_t sb_q[$];
   int   vectors;
   int   fails;
   int   t;
   logic prev_hs, prev_vs;
   int   hs_run, vs_run, hs_last_rise;
   bit   hs_seen_rise, hs_seen_fall, vs_seen_fall;

   // Spot checks on the first visible line (y=0) and on y=10.
   localparam int N_SPOT = 10;
   int         spot_h [N_SPOT] = '{144, 223, 224, 304, 703, 783, 784, 100, 144, 145};
   int         spot_v [N_SPOT] = '{35, 35, 35, 35, 35, 35, 35, 35, 45, 45};
`ifdef VGA_BORDER_EN
   logic [7:0] spot_rgb [N_SPOT] = '{8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0,
                                     8'h00, 8'h00, 8'hE0, 8'hFF};
`else
   logic [7:0] spot_rgb [N_SPOT] = '{8'hFF, 8'hFF, 8'hFC, 8'h1F, 8'h03, 8'h00,
                                     8'h00, 8'h00, 8'hFF, 8'hFF};
`endif

   vga_control dut (
      .clk     (clk),
      .rst     (rst),
      .vga_hs  (vga_hs),
      .vga_vs  (vga_vs),
      .vga_rgb (vga_rgb)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Output expected at clk edge s after reset release: each pixel lasts two clks.
   function automatic exp_t model(input int s);
      int   p, h, v, x;
      exp_t e;
      p     = s / 2;
      h     = p % HT;
      v     = (p / HT) % VT;
      e.hs  = (h >= 96);
      e.vs  = (v >= 2);
      e.rgb = 8'h00;
      if (h >= 144 && h < 784 && v >= 35 && v < 515) begin
         x = h - 144;
         case (x / 80)
            0: e.rgb = 8'hFF;
            1: e.rgb = 8'hFC;
            2: e.rgb = 8'h1F;
            3: e.rgb = 8'h1C;
            4: e.rgb = 8'hE3;
            5: e.rgb = 8'hE0;
            6: e.rgb = 8'h03;
            default: e.rgb = 8'h00;
         endcase
`ifdef VGA_BORDER_EN
         if (x == 0 || x == 639 || v == 35 || v == 514) e.rgb = 8'hE0;
`endif
      end
      return e;
   endfunction

   function automatic exp_t pins();
      return {vga_hs, vga_vs, vga_rgb};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at s=%0d: observed %0h expected %0h", tag, t - 1, obs, exp);
      end
   endtask

   task automatic restart();
      t            = 0;
      sb_q.delete();
      prev_hs      = 1'b1;
      prev_vs      = 1'b1;
      hs_run       = 0;
      vs_run       = 0;
      hs_last_rise = 0;
      hs_seen_rise = 1'b0;
      hs_seen_fall = 1'b0;
      vs_seen_fall = 1'b0;
   endtask

   task automatic check_reset_pins(input string tag);
      exp_t e;
      sb_q.push_back(RESET_EXP);
      e = sb_q.pop_front();
      check(tag, 32'(pins()), 32'(e));
   endtask

   task automatic reset_step();
      @(posedge clk);
      #1;
      check_reset_pins("reset_hold");
   endtask

   task automatic step();
      exp_t e;
      logic hs_fall, hs_rise, vs_fall, vs_rise;
      @(posedge clk);
      sb_q.push_back(model(t));
      t++;
      #1;
      e = sb_q.pop_front();
      check("pixel", 32'(pins()), 32'(e));
      for (int i = 0; i < N_SPOT; i++) begin
         if ((t - 1) == 2 * (spot_v[i] * HT + spot_h[i]))
            check("spot_rgb", 32'(vga_rgb), 32'(spot_rgb[i]));
      end
      hs_fall = prev_hs && !vga_hs;
      hs_rise = !prev_hs && vga_hs;
      vs_fall = prev_vs && !vga_vs;
      vs_rise = !prev_vs && vga_vs;
      if (hs_rise) begin
         if (hs_seen_fall) check("hs_low_len", 32'(hs_run), 32'(192));
         if (hs_seen_rise) check("hs_period", 32'(t - hs_last_rise), 32'(1600));
         hs_last_rise = t;
         hs_seen_rise = 1'b1;
      end
      if (hs_fall) begin
         if (hs_seen_rise) check("hs_high_len", 32'(hs_run), 32'(1408));
         hs_seen_fall = 1'b1;
      end
      hs_run = (hs_rise || hs_fall) ? 1 : hs_run + 1;
      if (vs_rise && vs_seen_fall) check("vs_low_len", 32'(vs_run), 32'(3200));
      if (vs_fall) begin
         check("vs_hs_align", 32'(hs_fall), 32'(1));
         vs_seen_fall = 1'b1;
      end
      vs_run  = (vs_rise || vs_fall) ? 1 : vs_run + 1;
      prev_hs = vga_hs;
      prev_vs = vga_vs;
   endtask

   initial begin
      vectors = 0;
      fails   = 0;
      restart();

      // Power-on reset held for three clocks.
      rst = 1'b1;
      #1;
      check_reset_pins("reset_async");
      for (int i = 0; i < 3; i++) reset_step();

      @(negedge clk);
      rst = 1'b0;
      restart();
      step();
      check("hs_first_clk", 32'(vga_hs), 32'(0));
      check("vs_first_clk", 32'(vga_vs), 32'(0));

      // Run through vsync, vertical blanking and into the visible lines up to y=11, h=400.
      do begin
         step();
      end while (!((t - 1) > 2 * 46 * HT && ((t - 1) % 2) == 0 && (((t - 1) / 2) % HT) == 400));

      // Mid-line reset: outputs must drop to reset values without a clock edge.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_pins("midline_async");
      reset_step();
      @(negedge clk);
      rst = 1'b0;
      restart();
      step();
      check("hs_after_midreset", 32'(vga_hs), 32'(0));
      check("vs_after_midreset", 32'(vga_vs), 32'(0));
      for (int i = 0; i < 3400; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
